lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store controller upstream of the byte-addressed data memory (mem). Accepts sized CPU load/store
//  requests, drives the memory's full-width rd_en/wr_en strobes, and performs read-modify-write for
//  sub-width stores. Returns zero/sign-extended load data with an error flag.
//  Sits between the Ember execute stage and mem; one request in flight at a time.
// PARAMETERS
//  DEPTH    1024  memory size in bytes; must match the mem instance
//  DATA_W   64    data/address width; BYTES = DATA_W/8 bytes touched per memory access
//  TIMEOUT  16    cycles to wait for rd_done/wr_done before flagging error
// PORTS
//  clk          in   1       clock; all logic on posedge
//  rst          in   1       synchronous, active-high reset
//  req_valid    in   1       request present
//  req_ready    out  1       controller can accept (high only in IDLE)
//  req_we       in   1       1=store, 0=load
//  req_size     in   2       0=8b, 1=16b, 2=32b, 3=DATA_W bits
//  req_signed   in   1       loads: sign-extend when 1, zero-extend when 0
//  req_addr     in   DATA_W  byte address
//  req_wdata    in   DATA_W  store data; low (8<<req_size) bits used
//  resp_valid   out  1       one-cycle response pulse; no backpressure
//  resp_rdata   out  DATA_W  load result (0 for stores/errors)
//  resp_err     out  1       valid with resp_valid: range error or timeout
//  mem_rd_en    out  1       to mem.rd_en
//  mem_wr_en    out  1       to mem.wr_en
//  mem_addr     out  DATA_W  to mem.addr
//  mem_wr_data  out  DATA_W  to mem.wr_data
//  mem_rd_data  in   DATA_W  from mem.rd_data
//  mem_rd_done  in   1       from mem.rd_done
//  mem_wr_done  in   1       from mem.wr_done
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0,
//    mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, timeout counter=0.
//  - Accept on req_valid&&req_ready (cycle N); latch we/size/signed/addr/wdata. req_ready=0 until IDLE again.
//  - Range check at accept: addr > DEPTH-BYTES -> state RESP with resp_err=1; no memory strobe. Resp in N+1.
//  - States: IDLE, RD, WAIT_RD, WR, WAIT_WR, RESP.
//  - Load: RD (mem_rd_en=1 one cycle, N+1) -> WAIT_RD until mem_rd_done -> RESP. resp_valid at N+3.
//    Result = low (8<<size) bits of mem_rd_data, extended per req_signed; size 3 passes through.
//  - Full-width store (size 3): WR (mem_wr_en=1, mem_wr_data=wdata, N+1) -> WAIT_WR -> RESP; resp at N+3.
//  - Sub-width store (size 0..2): RD/WAIT_RD, then WR with merged data = read word with low (1<<size)
//    bytes replaced by wdata low bytes; upper bytes preserved -> WAIT_WR -> RESP; resp at N+5.
//  - mem_rd_en/mem_wr_en strictly one-cycle pulses, never both high; mem_addr = latched addr, held stable
//    from strobe until done.
//  - Timeout: counter resets on each strobe, increments in WAIT_*; reaching TIMEOUT -> RESP with
//    resp_err=1, resp_rdata=0. A done arriving later in IDLE is ignored.
//  - Done pulses not expected for the current WAIT state (e.g. wr_done in WAIT_RD) are ignored.
//  - RESP lasts one cycle: resp_valid=1, then IDLE with req_ready=1; a new request may be accepted
//    the cycle after resp_valid. resp_rdata/resp_err hold until next response; resp_err=0 on success.
//  - rst mid-operation: abandon transaction immediately, no response issued, outputs to reset values;
//    a store already strobed to mem may or may not have completed.
// TESTING
//  1. Dword store addr=0x10 data=0x1122334455667788, then dword load 0x10 -> wr strobe N+1, resp N+3;
//     load resp_rdata=0x1122334455667788, resp_err=0.
//  2. Byte store 0xAB at 0x10 over test 1 data -> rd strobe N+1, wr strobe N+3 data=0x11223344556677AB,
//     resp N+5; dword load returns 0x11223344556677AB.
//  3. Loads at 0x10 after test 2: size0 signed -> 0xFFFFFFFFFFFFFFAB; size0 unsigned -> 0xAB;
//     size2 signed -> 0x00000000556677AB.
//  4. Load addr=DEPTH-7 (1017) -> no mem strobe, resp_valid at N+1, resp_err=1, resp_rdata=0;
//     addr=DEPTH-8 (1016) succeeds.
//  5. Stub mem that never asserts done: load -> resp_err=1 after TIMEOUT cycles in WAIT_RD;
//     late rd_done ignored, req_ready=1.
//  6. Assert rst in WAIT_WR of a sub-width store -> next cycle all outputs at reset values, no
//     resp_valid; new load accepted right after rst deasserts.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and memory-side signal bundle for the load/store controller.
// The slave modport is the controller's view; master is the CPU plus memory side.
interface lsu_mem_ctrl_if #(
  parameter int DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_done;
  logic              mem_wr_done;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  mem_rd_data, mem_rd_done, mem_wr_done,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_rd_en, mem_wr_en, mem_addr, mem_wr_data
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output mem_rd_data, mem_rd_done, mem_wr_done,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store controller in front of a full-width byte-addressed memory.
// Sub-width stores are done as read-modify-write; loads are zero/sign-extended by size.
module lsu_mem_ctrl #(
  parameter int DEPTH   = 1024,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input logic         clk,
  input logic         rst,
  lsu_mem_ctrl_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] MAX_ADDR = DATA_W'(DEPTH - BYTES);

  typedef enum logic [2:0] {IDLE, RD, WAIT_RD, WR, WAIT_WR, RESP} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;

  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] d,
                                                 input logic [1:0] sz, input logic sgn);
    logic [DATA_W-1:0] r;
    r = d;
    case (sz)
      2'd0:    r = {{(DATA_W-8){sgn & d[7]}}, d[7:0]};
      2'd1:    r = {{(DATA_W-16){sgn & d[15]}}, d[15:0]};
      2'd2:    r = {{(DATA_W-32){sgn & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Low (1<<sz) bytes come from the store data, the rest from the word just read.
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] rd,
                                              input logic [DATA_W-1:0] wd, input logic [1:0] sz);
    logic [DATA_W-1:0] r;
    r = wd;
    case (sz)
      2'd0:    r = {rd[DATA_W-1:8], wd[7:0]};
      2'd1:    r = {rd[DATA_W-1:16], wd[15:0]};
      2'd2:    r = {rd[DATA_W-1:32], wd[31:0]};
      default: r = wd;
    endcase
    return r;
  endfunction

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    size_d        = size_q;
    signed_d      = signed_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    req_ready_d   = req_ready_q;
    resp_valid_d  = 1'b0;
    resp_rdata_d  = resp_rdata_q;
    resp_err_d    = resp_err_q;
    mem_rd_en_d   = 1'b0;
    mem_wr_en_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          we_d        = bus.req_we;
          size_d      = bus.req_size;
          signed_d    = bus.req_signed;
          wdata_d     = bus.req_wdata;
          req_ready_d = 1'b0;
          if (bus.req_addr > MAX_ADDR) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            mem_addr_d = bus.req_addr;
            cnt_d      = '0;
            if (bus.req_we && (bus.req_size == 2'd3)) begin
              state_d       = WR;
              mem_wr_en_d   = 1'b1;
              mem_wr_data_d = bus.req_wdata;
            end else begin
              state_d     = RD;
              mem_rd_en_d = 1'b1;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD: state_d = WAIT_RD;
      WAIT_RD: begin
        if (bus.mem_rd_done) begin
          if (we_q) begin
            state_d       = WR;
            mem_wr_en_d   = 1'b1;
            mem_wr_data_d = merge(bus.mem_rd_data, wdata_q, size_q);
            cnt_d         = '0;
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = load_ext(bus.mem_rd_data, size_q, signed_q);
          end
        end else if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR: state_d = WAIT_WR;
      WAIT_WR: begin
        if (bus.mem_wr_done) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
        end else if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      size_q        <= 2'd0;
      signed_q      <= 1'b0;
      wdata_q       <= '0;
      cnt_q         <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_err_q    <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      size_q        <= size_d;
      signed_q      <= signed_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.mem_rd_en   = mem_rd_en_q;
  assign bus.mem_wr_en   = mem_wr_en_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a one-cycle-latency byte memory model,
// a stall mode that never answers, and injectable late done pulses.
module tb_lsu_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  lsu_mem_ctrl_if #(.DATA_W(64)) bus ();

  lsu_mem_ctrl #(.DEPTH(1024), .DATA_W(64), .TIMEOUT(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] mem_b [0:1023] = '{default: 8'h00};
  logic mem_stall = 1'b0;
  logic model_rd_done = 1'b0;
  logic model_wr_done = 1'b0;
  logic inj_rd_done = 1'b0;
  logic [63:0] model_rd_data = 64'h0;

  assign bus.mem_rd_done = model_rd_done | inj_rd_done;
  assign bus.mem_wr_done = model_wr_done;
  assign bus.mem_rd_data = model_rd_data;

  // Little-endian memory: byte addr is the least significant byte of the word.
  always @(posedge clk) begin
    if (rst) begin
      model_rd_done <= 1'b0;
      model_wr_done <= 1'b0;
    end else begin
      model_rd_done <= bus.mem_rd_en & ~mem_stall;
      model_wr_done <= bus.mem_wr_en & ~mem_stall;
      if (bus.mem_rd_en)
        for (int i = 0; i < 8; i++)
          model_rd_data[i*8 +: 8] <= mem_b[bus.mem_addr[9:0] + 10'(i)];
      if (bus.mem_wr_en)
        for (int i = 0; i < 8; i++)
          mem_b[bus.mem_addr[9:0] + 10'(i)] <= bus.mem_wr_data[i*8 +: 8];
    end
  end

  // Issues one request and records, relative to the accept cycle N, when strobes and the response appear.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [63:0] ad, input logic [63:0] wd,
                        output int rd_at, output int wr_at, output int resp_at,
                        output logic [63:0] wdat, output logic [63:0] rdata, output logic err);
    rd_at = -1; wr_at = -1; resp_at = -1; wdat = 64'h0; rdata = 64'h0; err = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = ad; bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 40 && resp_at < 0; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.mem_rd_en && rd_at < 0) rd_at = k;
      if (bus.mem_wr_en && wr_at < 0) begin wr_at = k; wdat = bus.mem_wr_data; end
      if (bus.resp_valid) begin resp_at = k; rdata = bus.resp_rdata; err = bus.resp_err; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0)
      $display("FAIL reset_ctrl: got ready=%b valid=%b err=%b, want 1 0 0",
               bus.req_ready, bus.resp_valid, bus.resp_err);
    checks++;
    if (bus.mem_rd_en !== 1'b0 || bus.mem_wr_en !== 1'b0 || bus.mem_addr !== 64'h0 ||
        bus.mem_wr_data !== 64'h0 || bus.resp_rdata !== 64'h0)
      $display("FAIL reset_data: got rd=%b wr=%b addr=%h wdata=%h rdata=%h, want all 0",
               bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data, bus.resp_rdata);
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0) errors++;
    else if (bus.mem_rd_en !== 1'b0 || bus.mem_wr_en !== 1'b0 || bus.mem_addr !== 64'h0 ||
             bus.mem_wr_data !== 64'h0 || bus.resp_rdata !== 64'h0) errors++;
    rst = 1'b0;
  endtask

  task automatic test_dword();
    int rd, wr, rs; logic [63:0] wdat, rdat; logic er;
    do_req(1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788, rd, wr, rs, wdat, rdat, er);
    checks++;
    if (rd !== -1 || wr !== 1 || rs !== 3 || wdat !== 64'h1122334455667788 || er !== 1'b0) begin
      errors++;
      $display("FAIL dw_store: got rd=%0d wr=%0d resp=%0d wdata=%h err=%b, want -1 1 3 1122334455667788 0",
               rd, wr, rs, wdat, er);
    end
    do_req(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, rd, wr, rs, wdat, rdat, er);
    checks++;
    if (rd !== 1 || wr !== -1 || rs !== 3 || rdat !== 64'h1122334455667788 || er !== 1'b0) begin
      errors++;
      $display("FAIL dw_load: got rd=%0d wr=%0d resp=%0d rdata=%h err=%b, want 1 -1 3 1122334455667788 0",
               rd, wr, rs, rdat, er);
    end
  endtask

  task automatic test_subword_store();
    int rd, wr, rs; logic [63:0] wdat, rdat; logic er;
    do_req(1'b1, 2'd0, 1'b0, 64'h10, 64'hFFFF_FFFF_FFFF_FFAB, rd, wr, rs, wdat, rdat, er);
    checks++;
    if (rd !== 1 || wr !== 3 || rs !== 5 || wdat !== 64'h11223344556677AB || er !== 1'b0) begin
      errors++;
      $display("FAIL byte_store: got rd=%0d wr=%0d resp=%0d wdata=%h err=%b, want 1 3 5 11223344556677ab 0",
               rd, wr, rs, wdat, er);
    end
    do_req(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, rd, wr, rs, wdat, rdat, er);
    checks++;
    if (rdat !== 64'h11223344556677AB || er !== 1'b0) begin
      errors++;
      $display("FAIL byte_store_readback: got %h err=%b, want 11223344556677ab 0", rdat, er);
    end
    do_req(1'b1, 2'd3, 1'b0, 64'h30, 64'h0000_0000_8000_0001, rd, wr, rs, wdat, rdat, er);
    do_req(1'b1, 2'd1, 1'b0, 64'h30, 64'h0000_0000_0000_BEEF, rd, wr, rs, wdat, rdat, er);
    checks++;
    if (wdat !== 64'h000000008000BEEF || rs !== 5) begin
      errors++;
      $display("FAIL half_store: got wdata=%h resp=%0d, want 000000008000beef 5", wdat, rs);
    end
  endtask

  task automatic test_load_ext();
    int rd, wr, rs; logic [63:0] wdat, rdat; logic er;
    do_req(1'b0, 2'd0, 1'b1, 64'h10, 64'h0, rd, wr, rs, wdat, rdat, er);
    checks++;
    if (rdat !== 64'hFFFFFFFFFFFFFFAB) begin
      errors++; $display("FAIL lb_signed: got %h, want ffffffffffffffab", rdat);
    end
    do_req(1'b0, 2'd0, 1'b0, 64'h10, 64'h0, rd, wr, rs, wdat, rdat, er);
    checks++;
    if (rdat !== 64'h00000000000000AB) begin
      errors++; $display("FAIL lb_unsigned: got %h, want 00000000000000ab", rdat);
    end
    do_req(1'b0, 2'd2, 1'b1, 64'h10, 64'h0, rd, wr, rs, wdat, rdat, er);
    checks++;
    if (rdat !== 64'h00000000556677AB) begin
      errors++; $display("FAIL lw_signed_pos: got %h, want 00000000556677ab", rdat);
    end
    do_req(1'b0, 2'd1, 1'b1, 64'h30, 64'h0, rd, wr, rs, wdat, rdat, er);
    checks++;
    if (rdat !== 64'hFFFFFFFFFFFFBEEF) begin
      errors++; $display("FAIL lh_signed_neg: got %h, want ffffffffffffbeef", rdat);
    end
    do_req(1'b0, 2'd2, 1'b1, 64'h30, 64'h0, rd, wr, rs, wdat, rdat, er);
    checks++;
    if (rdat !== 64'hFFFFFFFF8000BEEF) begin
      errors++; $display("FAIL lw_signed_neg: got %h, want ffffffff8000beef", rdat);
    end
    do_req(1'b1, 2'd2, 1'b0, 64'h10, 64'h12345678, rd, wr, rs, wdat, rdat, er);
    checks++;
    if (wdat !== 64'h1122334412345678) begin
      errors++; $display("FAIL word_store_merge: got %h, want 1122334412345678", wdat);
    end
  endtask

  task automatic test_range();
    int rd, wr, rs; logic [63:0] wdat, rdat; logic er;
    do_req(1'b0, 2'd3, 1'b0, 64'd1017, 64'h0, rd, wr, rs, wdat, rdat, er);
    checks++;
    if (rd !== -1 || wr !== -1 || rs !== 1 || er !== 1'b1 || rdat !== 64'h0) begin
      errors++;
      $display("FAIL range_load_1017: got rd=%0d wr=%0d resp=%0d err=%b rdata=%h, want -1 -1 1 1 0",
               rd, wr, rs, er, rdat);
    end
    do_req(1'b1, 2'd3, 1'b0, 64'd1017, 64'h5555, rd, wr, rs, wdat, rdat, er);
    checks++;
    if (wr !== -1 || rs !== 1 || er !== 1'b1) begin
      errors++;
      $display("FAIL range_store_1017: got wr=%0d resp=%0d err=%b, want -1 1 1", wr, rs, er);
    end
    do_req(1'b1, 2'd3, 1'b0, 64'd1016, 64'hCAFEBABEDEADBEEF, rd, wr, rs, wdat, rdat, er);
    do_req(1'b0, 2'd3, 1'b0, 64'd1016, 64'h0, rd, wr, rs, wdat, rdat, er);
    checks++;
    if (rs !== 3 || er !== 1'b0 || rdat !== 64'hCAFEBABEDEADBEEF) begin
      errors++;
      $display("FAIL range_load_1016: got resp=%0d err=%b rdata=%h, want 3 0 cafebabedeadbeef",
               rs, er, rdat);
    end
  endtask

  task automatic test_timeout();
    int rd, wr, rs; logic [63:0] wdat, rdat; logic er;
    mem_stall = 1'b1;
    do_req(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, rd, wr, rs, wdat, rdat, er);
    mem_stall = 1'b0;
    checks++;
    if (rs !== 18 || er !== 1'b1 || rdat !== 64'h0) begin
      errors++;
      $display("FAIL timeout: got resp=%0d err=%b rdata=%h, want 18 1 0", rs, er, rdat);
    end
    inj_rd_done = 1'b1;
    @(negedge clk);
    inj_rd_done = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL late_done: got ready=%b valid=%b, want 1 0", bus.req_ready, bus.resp_valid);
    end
    do_req(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, rd, wr, rs, wdat, rdat, er);
    checks++;
    if (rs !== 3 || er !== 1'b0 || rdat !== 64'h1122334412345678) begin
      errors++;
      $display("FAIL after_timeout: got resp=%0d err=%b rdata=%h, want 3 0 1122334412345678",
               rs, er, rdat);
    end
  endtask

  task automatic test_mid_reset();
    int rd, wr, rs; logic [63:0] wdat, rdat; logic er;
    logic wr_seen;
    wr_seen = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 64'h18; bus.req_wdata = 64'h5A;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      if (k == 3 && bus.mem_wr_en === 1'b1) wr_seen = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (!wr_seen || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 ||
        bus.mem_rd_en !== 1'b0 || bus.mem_wr_en !== 1'b0 || bus.mem_addr !== 64'h0 ||
        bus.mem_wr_data !== 64'h0 || bus.resp_rdata !== 64'h0) begin
      errors++;
      $display("FAIL mid_reset: got wr_seen=%b ready=%b valid=%b err=%b rd=%b wr=%b addr=%h wd=%h rdata=%h, want 1 1 0 0 0 0 0 0 0",
               wr_seen, bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_rd_en,
               bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data, bus.resp_rdata);
    end
    rst = 1'b0;
    do_req(1'b0, 2'd3, 1'b0, 64'h18, 64'h0, rd, wr, rs, wdat, rdat, er);
    checks++;
    if (rs !== 3 || er !== 1'b0 || rdat !== 64'h5A) begin
      errors++;
      $display("FAIL post_reset_load: got resp=%0d err=%b rdata=%h, want 3 0 5a", rs, er, rdat);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 64'h0; bus.req_wdata = 64'h0;
    test_reset();
    test_dword();
    test_subword_store();
    test_load_ext();
    test_range();
    test_timeout();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
